// File: rtl/conv_acc_pkg.sv
// Shared types and constants for the conv accelerator host-side feeder.
package conv_acc_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WHT   = 3'd3,
    IFM   = 3'd4,
    OUT   = 3'd5,
    DONE  = 3'd6
  } feeder_state_e;

endpackage

// File: rtl/conv_acc_feeder_if.sv
// Memory and accelerator stream bundle between the feeder (master) and its environment (slave).
interface conv_acc_feeder_if #(
  parameter int AW = 14
);
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          conv_start;
  logic [7:0]    wht;
  logic          wht_valid;
  logic          wht_ready;
  logic [7:0]    ifm;
  logic          ifm_valid;
  logic          ifm_ready;
  logic [31:0]   out;
  logic          out_valid;
  logic          out_ready;
  logic          conv_end;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, conv_start,
    output wht, wht_valid, ifm, ifm_valid, out_ready,
    input  rd_data, wht_ready, ifm_ready, out, out_valid, conv_end
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, conv_start,
    input  wht, wht_valid, ifm, ifm_valid, out_ready,
    output rd_data, wht_ready, ifm_ready, out, out_valid, conv_end
  );
endinterface

// File: rtl/conv_acc_feeder_word_byte_ser.sv
// Holds one 32-bit word and hands it out LSB byte first over an 8-bit valid/ready port.
module word_byte_ser
  import conv_acc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_en,
  input  logic [31:0] ld_data,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [7:0]  byte_o,
  output logic        last_byte_o
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic        full_q, full_d;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    full_d = full_q;
    if (full_q && ready_i) begin
      idx_d = idx_q + 2'd1;
      if (idx_q == LAST_IDX) full_d = 1'b0;
    end
    // A load only arrives once the previous word has fully drained.
    if (ld_en) begin
      word_d = ld_data;
      idx_d  = '0;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q <= '0;
      idx_q  <= '0;
      full_q <= 1'b0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
      full_q <= full_d;
    end
  end

  always_comb begin
    byte_o = word_q[7:0];
    case (idx_q)
      2'd1:    byte_o = word_q[15:8];
      2'd2:    byte_o = word_q[23:16];
      2'd3:    byte_o = word_q[31:24];
      default: byte_o = word_q[7:0];
    endcase
  end

  assign valid_o     = full_q;
  assign last_byte_o = (idx_q == LAST_IDX);

endmodule

// File: rtl/conv_acc_feeder.sv
// Streams weight/ifm words from buffer memory into the accelerator byte ports,
// then drains accelerator results back into memory; one run per conv tile.
module conv_acc_feeder
  import conv_acc_pkg::*;
#(
  parameter int AW    = 14,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    wht_base,
  input  logic [CNT_W-1:0] wht_words,
  input  logic [AW-1:0]    ifm_base,
  input  logic [CNT_W-1:0] ifm_words,
  input  logic [AW-1:0]    out_base,
  input  logic [CNT_W-1:0] out_words,
  output logic             busy,
  output logic             done,
  output logic             err,
  conv_acc_feeder_if.master bus
);

  feeder_state_e state_q, state_d;
  feeder_state_e first_phase, after_wht;

  logic [AW-1:0]    wht_base_q, wht_base_d, ifm_base_q, ifm_base_d, out_base_q, out_base_d;
  logic [CNT_W-1:0] wht_words_q, wht_words_d, ifm_words_q, ifm_words_d, out_words_q, out_words_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d, res_cnt_q, res_cnt_d;
  logic             rd_pend_q, rd_pend_d, end_seen_q, end_seen_d, err_q, err_d;

  logic             start_acc, phase_act, words_done, byte_hs, last_hs, rd_req, phase_end;
  logic             res_pend, res_hs, cnt_reached, end_now;
  logic [AW-1:0]    cur_base;
  logic [CNT_W-1:0] cur_words;
  logic [7:0]       ser_byte;
  logic             ser_valid, ser_ready, ser_last;

  assign start_acc   = (state_q == IDLE) && start;
  assign phase_act   = (state_q == WHT) || (state_q == IFM);
  assign cur_base    = (state_q == WHT) ? wht_base_q : ifm_base_q;
  assign cur_words   = (state_q == WHT) ? wht_words_q : ifm_words_q;
  assign words_done  = (rd_cnt_q == cur_words);
  assign byte_hs     = ser_valid && ser_ready;
  assign last_hs     = byte_hs && ser_last;
  // First word is fetched on phase entry; later words on the last-byte handshake.
  assign rd_req      = phase_act && !words_done && ((rd_cnt_q == '0) || last_hs);
  assign phase_end   = phase_act && words_done && last_hs;
  assign res_pend    = (state_q == OUT) && (res_cnt_q != out_words_q);
  assign res_hs      = res_pend && bus.out_valid;
  assign cnt_reached = (res_cnt_q == out_words_q) ||
                       (res_hs && ((res_cnt_q + CNT_W'(1)) == out_words_q));
  assign end_now     = end_seen_q || bus.conv_end;
  assign after_wht   = (ifm_words_q != '0) ? IFM : OUT;
  assign first_phase = (wht_words_q != '0) ? WHT : after_wht;

  word_byte_ser u_ser (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld_en       (rd_pend_q),
    .ld_data     (bus.rd_data),
    .ready_i     (ser_ready),
    .valid_o     (ser_valid),
    .byte_o      (ser_byte),
    .last_byte_o (ser_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = START;
      START:   state_d = first_phase;
      WHT:     if (phase_end) state_d = after_wht;
      IFM:     if (phase_end) state_d = OUT;
      OUT:     if (end_now) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state_q != IDLE);
    done           = (state_q == DONE);
    err            = err_q;
    bus.conv_start = (state_q == START);
    bus.rd_en      = rd_req;
    bus.rd_addr    = rd_req ? (cur_base + AW'(rd_cnt_q)) : '0;
    bus.wht_valid  = (state_q == WHT) && ser_valid;
    bus.wht        = ((state_q == WHT) && ser_valid) ? ser_byte : '0;
    bus.ifm_valid  = (state_q == IFM) && ser_valid;
    bus.ifm        = ((state_q == IFM) && ser_valid) ? ser_byte : '0;
    ser_ready      = (state_q == WHT) ? bus.wht_ready :
                     (state_q == IFM) ? bus.ifm_ready : 1'b0;
    bus.out_ready  = res_pend;
    bus.wr_en      = res_hs;
    bus.wr_addr    = res_hs ? (out_base_q + AW'(res_cnt_q)) : '0;
    bus.wr_data    = res_hs ? bus.out : '0;
  end

  always_comb begin
    wht_base_d  = wht_base_q;
    ifm_base_d  = ifm_base_q;
    out_base_d  = out_base_q;
    wht_words_d = wht_words_q;
    ifm_words_d = ifm_words_q;
    out_words_d = out_words_q;
    rd_cnt_d    = rd_cnt_q;
    res_cnt_d   = res_cnt_q;
    rd_pend_d   = rd_req;
    end_seen_d  = end_seen_q;
    err_d       = err_q;
    if (start_acc) begin
      wht_base_d  = wht_base;
      ifm_base_d  = ifm_base;
      out_base_d  = out_base;
      wht_words_d = wht_words;
      ifm_words_d = ifm_words;
      out_words_d = out_words;
      res_cnt_d   = '0;
      end_seen_d  = 1'b0;
      err_d       = 1'b0;
    end
    if (!phase_act || phase_end) rd_cnt_d = '0;
    else if (rd_req)             rd_cnt_d = rd_cnt_q + CNT_W'(1);
    if (res_hs) res_cnt_d = res_cnt_q + CNT_W'(1);
    if (bus.conv_end && (state_q inside {START, WHT, IFM, OUT})) end_seen_d = 1'b1;
    // End-of-tile while results are still owed marks the run as failed.
    if ((state_q == OUT) && end_now && !cnt_reached) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_cnt_q   <= '0;
      res_cnt_q  <= '0;
      rd_pend_q  <= 1'b0;
      end_seen_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_cnt_q   <= rd_cnt_d;
      res_cnt_q  <= res_cnt_d;
      rd_pend_q  <= rd_pend_d;
      end_seen_q <= end_seen_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    wht_base_q  <= wht_base_d;
    ifm_base_q  <= ifm_base_d;
    out_base_q  <= out_base_d;
    wht_words_q <= wht_words_d;
    ifm_words_q <= ifm_words_d;
    out_words_q <= out_words_d;
  end

endmodule

// File: tb/tb_conv_acc_feeder.sv
// Directed bench for conv_acc_feeder: memory model, accelerator stub and stream monitor.
module tb_conv_acc_feeder;

  localparam int AW    = 14;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n, start;
  logic [AW-1:0]    wht_base, ifm_base, out_base;
  logic [CNT_W-1:0] wht_words, ifm_words, out_words;
  logic             busy, done, err;

  always #5 clk = ~clk;

  conv_acc_feeder_if #(.AW(AW)) bus ();

  conv_acc_feeder #(.AW(AW), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .wht_base  (wht_base),
    .wht_words (wht_words),
    .ifm_base  (ifm_base),
    .ifm_words (ifm_words),
    .out_base  (out_base),
    .out_words (out_words),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bus       (bus)
  );

  logic [31:0]   mem [0:(1<<AW)-1];
  logic          tb_we = 1'b0;
  logic [AW-1:0] tb_waddr = '0;
  logic [31:0]   tb_wdata = '0;

  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
    else if (tb_we) mem[tb_waddr] <= tb_wdata;
  end

  logic [7:0] wht_q[$], ifm_q[$];
  int         wht_t[$], ifm_t[$];
  int  cyc = 0, n_cs = 0, n_done = 0, n_rd = 0, n_vld = 0, n_excl = 0, n_stab = 0;
  int  cs_t = 0, dn_t = 0;
  logic       p_wv = 1'b0, p_iv = 1'b0;
  logic [7:0] p_wb = '0, p_ib = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (bus.wht_valid && bus.wht_ready) begin
        wht_q.push_back(bus.wht);
        wht_t.push_back(cyc);
      end
      if (bus.ifm_valid && bus.ifm_ready) begin
        ifm_q.push_back(bus.ifm);
        ifm_t.push_back(cyc);
      end
      if (bus.conv_start) begin
        n_cs <= n_cs + 1;
        cs_t <= cyc;
      end
      if (done) begin
        n_done <= n_done + 1;
        dn_t   <= cyc;
      end
      if (bus.rd_en) n_rd <= n_rd + 1;
      if (bus.wht_valid || bus.ifm_valid) n_vld <= n_vld + 1;
      if ((bus.rd_en && bus.wr_en) || (bus.wht_valid && bus.ifm_valid)) n_excl <= n_excl + 1;
      if ((p_wv && (!bus.wht_valid || bus.wht != p_wb)) ||
          (p_iv && (!bus.ifm_valid || bus.ifm != p_ib))) n_stab <= n_stab + 1;
    end
    p_wv <= rst_n && bus.wht_valid && !bus.wht_ready;
    p_iv <= rst_n && bus.ifm_valid && !bus.ifm_ready;
    p_wb <= bus.wht;
    p_ib <= bus.ifm;
  end

  int          n_assert = 0, n_fail = 0;
  int          tcyc = 0, res_i = 0, n_res = 0, end_cyc = -1, end_res = -1;
  bit          end_fired = 1'b0, rnd = 1'b0;
  logic [31:0] res_v [0:2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [31:0] d);
    tb_we    = 1'b1;
    tb_waddr = a;
    tb_wdata = d;
    @(posedge clk);
    #1;
    tb_we    = 1'b0;
  endtask

  task automatic step();
    logic hs;
    hs = bus.out_valid && bus.out_ready;
    @(posedge clk);
    #1;
    tcyc++;
    start = 1'b0;
    if (hs) res_i++;
    if (rnd) begin
      bus.wht_ready = 1'($urandom_range(0, 1));
      bus.ifm_ready = 1'($urandom_range(0, 1));
    end
    bus.out_valid = (res_i < n_res);
    bus.out       = (res_i < n_res) ? res_v[res_i] : '0;
    bus.conv_end  = 1'b0;
    if (!end_fired && ((end_cyc >= 0 && tcyc == end_cyc) || (end_res >= 0 && res_i == end_res))) begin
      bus.conv_end = 1'b1;
      end_fired    = 1'b1;
    end
  endtask

  task automatic begin_run(input logic [CNT_W-1:0] ww, input logic [CNT_W-1:0] iw,
                           input logic [CNT_W-1:0] ow, input logic [AW-1:0] wb,
                           input logic [AW-1:0] ib, input logic [AW-1:0] ob);
    wht_words = ww; ifm_words = iw; out_words = ow;
    wht_base  = wb; ifm_base  = ib; out_base  = ob;
    tcyc = 0; res_i = 0; end_fired = 1'b0;
    bus.out_valid = (n_res > 0);
    bus.out       = (n_res > 0) ? res_v[0] : '0;
    bus.conv_end  = 1'b0;
    start = 1'b1;
  endtask

  task automatic run_to_done(input int max, input string tag);
    int d0 = n_done;
    int k  = 0;
    while (n_done == d0 && k < max) begin
      step();
      k++;
    end
    chk({tag, "_done_seen"}, 32'(n_done != d0), 32'd1);
    repeat (3) step();
  endtask

  initial begin
    int w0, i0, cs0, d0, st0, ex0, rd0, v0, k;
    rst_n = 1'b0; start = 1'b0;
    wht_base = '0; ifm_base = '0; out_base = '0;
    wht_words = '0; ifm_words = '0; out_words = '0;
    bus.wht_ready = 1'b1; bus.ifm_ready = 1'b1;
    bus.out = '0; bus.out_valid = 1'b0; bus.conv_end = 1'b0;
    res_v[0] = '0; res_v[1] = '0; res_v[2] = '0;

    poke(14'd0,   32'h04030201);
    poke(14'd1,   32'h08070605);
    poke(14'd16,  32'h44332211);
    poke(14'd103, 32'hCAFEF00D);
    chk("reset_outputs", 32'({busy, done, err, bus.rd_en, bus.wr_en, bus.conv_start,
                              bus.wht_valid, bus.ifm_valid, bus.out_ready}), 32'd0);
    rst_n = 1'b1;
    step();

    // Test 1: two weight words, one ifm word, always ready
    w0 = wht_q.size(); i0 = ifm_q.size(); cs0 = n_cs; d0 = n_done; ex0 = n_excl;
    end_cyc = 20; end_res = -1; n_res = 0;
    begin_run(16'd2, 16'd1, 16'd0, 14'd0, 14'd16, 14'd0);
    run_to_done(60, "t1");
    chk("t1_wht_count", 32'(wht_q.size() - w0), 32'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("t1_wht_byte%0d", i), 32'(wht_q[w0+i]), 32'(i + 1));
    chk("t1_first_byte_lat", 32'(wht_t[w0] - cs_t), 32'd3);
    chk("t1_byte_spacing", 32'(wht_t[w0+1] - wht_t[w0]), 32'd1);
    chk("t1_word_spacing", 32'(wht_t[w0+4] - wht_t[w0]), 32'd5);
    chk("t1_ifm_count", 32'(ifm_q.size() - i0), 32'd4);
    chk("t1_ifm_byte0", 32'(ifm_q[i0]), 32'h11);
    chk("t1_ifm_byte3", 32'(ifm_q[i0+3]), 32'h44);
    chk("t1_ifm_lat", 32'(ifm_t[i0] - cs_t), 32'd14);
    chk("t1_conv_start_cnt", 32'(n_cs - cs0), 32'd1);
    chk("t1_done_cnt", 32'(n_done - d0), 32'd1);
    chk("t1_err", 32'(err), 32'd0);
    chk("t1_busy_idle", 32'(busy), 32'd0);

    // Test 2: random back-pressure on both byte channels
    w0 = wht_q.size(); i0 = ifm_q.size(); st0 = n_stab; d0 = n_done;
    rnd = 1'b1;
    begin_run(16'd2, 16'd1, 16'd0, 14'd0, 14'd16, 14'd0);
    run_to_done(400, "t2");
    rnd = 1'b0; bus.wht_ready = 1'b1; bus.ifm_ready = 1'b1;
    chk("t2_wht_count", 32'(wht_q.size() - w0), 32'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("t2_wht_byte%0d", i), 32'(wht_q[w0+i]), 32'(i + 1));
    chk("t2_ifm_count", 32'(ifm_q.size() - i0), 32'd4);
    chk("t2_ifm_byte1", 32'(ifm_q[i0+1]), 32'h22);
    chk("t2_stability", 32'(n_stab - st0), 32'd0);
    chk("t2_done_cnt", 32'(n_done - d0), 32'd1);
    chk("t2_exclusive", 32'(n_excl - ex0), 32'd0);

    // Test 3: three results written back, conv_end with the last one
    rd0 = n_rd; d0 = n_done;
    res_v[0] = 32'hFFFFFFF0; res_v[1] = 32'd5; res_v[2] = 32'd7; n_res = 3;
    end_cyc = -1; end_res = 2;
    begin_run(16'd0, 16'd0, 16'd3, 14'd0, 14'd0, 14'd100);
    run_to_done(40, "t3");
    chk("t3_mem100", mem[100], 32'hFFFFFFF0);
    chk("t3_mem101", mem[101], 32'd5);
    chk("t3_mem102", mem[102], 32'd7);
    chk("t3_mem103", mem[103], 32'hCAFEF00D);
    chk("t3_no_reads", 32'(n_rd - rd0), 32'd0);
    chk("t3_done_cnt", 32'(n_done - d0), 32'd1);
    chk("t3_err", 32'(err), 32'd0);

    // Test 4: conv_end after only two of three results
    poke(14'd102, 32'hDEADBEEF);
    d0 = n_done;
    res_v[0] = 32'h11; res_v[1] = 32'h22; res_v[2] = '0; n_res = 2;
    end_res = 2;
    begin_run(16'd0, 16'd0, 16'd3, 14'd0, 14'd0, 14'd100);
    run_to_done(40, "t4");
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_done_cnt", 32'(n_done - d0), 32'd1);
    chk("t4_mem100", mem[100], 32'h11);
    chk("t4_mem101", mem[101], 32'h22);
    chk("t4_mem102", mem[102], 32'hDEADBEEF);
    chk("t4_out_ready_idle", 32'(bus.out_ready), 32'd0);

    // Test 5: all-zero counts, second start while busy
    rd0 = n_rd; v0 = n_vld; cs0 = n_cs; d0 = n_done;
    n_res = 0; end_res = -1; end_cyc = 3;
    begin_run(16'd0, 16'd0, 16'd0, 14'd0, 14'd0, 14'd0);
    step();
    step();
    chk("t5_err_cleared", 32'(err), 32'd0);
    start = 1'b1;
    run_to_done(40, "t5");
    repeat (4) step();
    chk("t5_no_reads", 32'(n_rd - rd0), 32'd0);
    chk("t5_no_valid", 32'(n_vld - v0), 32'd0);
    chk("t5_conv_start_cnt", 32'(n_cs - cs0), 32'd1);
    chk("t5_done_cnt", 32'(n_done - d0), 32'd1);
    chk("t5_start_to_done", 32'(dn_t - cs_t), 32'd2);
    chk("t5_busy_idle", 32'(busy), 32'd0);

    // Test 6: reset during weight byte 2, then a clean replay
    w0 = wht_q.size();
    end_cyc = -1;
    begin_run(16'd2, 16'd1, 16'd0, 14'd0, 14'd16, 14'd0);
    k = 0;
    while ((wht_q.size() - w0) < 2 && k < 40) begin
      step();
      k++;
    end
    chk("t6_reach_byte2", 32'(k < 40), 32'd1);
    chk("t6_byte2_pre_reset", 32'({bus.wht_valid, bus.wht}), 32'h103);
    rst_n = 1'b0;
    step();
    chk("t6_reset_outputs", 32'({busy, done, err, bus.rd_en, bus.wr_en, bus.conv_start,
                                 bus.wht_valid, bus.ifm_valid, bus.out_ready}), 32'd0);
    chk("t6_reset_bus", 32'({bus.wht, bus.rd_addr}), 32'd0);
    rst_n = 1'b1;
    step();
    w0 = wht_q.size(); d0 = n_done;
    end_cyc = 20;
    begin_run(16'd2, 16'd1, 16'd0, 14'd0, 14'd16, 14'd0);
    run_to_done(60, "t6");
    chk("t6_wht_count", 32'(wht_q.size() - w0), 32'd8);
    chk("t6_replay_byte0", 32'(wht_q[w0]), 32'h01);
    chk("t6_replay_byte7", 32'(wht_q[w0+7]), 32'h08);
    chk("t6_done_cnt", 32'(n_done - d0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
